// File: rtl/npc_pkg.sv
// Shared definitions for the fetch-stage next-PC unit: opcodes, 2-bit predictor
// counter encodings, the reset PC and the counter update helper.
package npc_pkg;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Saturating step: never wraps from ST to SNT or from SNT to ST.
    function automatic ctr_e ctr_update(input ctr_e ctr, input logic taken);
        ctr_e nxt;
        nxt = ctr;
        if (taken && ctr != ST) begin
            nxt = ctr_e'(ctr + 2'd1);
        end else if (!taken && ctr != SNT) begin
            nxt = ctr_e'(ctr - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/npc_bpu_btb_mem.sv
// Direct-mapped branch target buffer: combinational lookup port, synchronous
// update port with 2-bit saturating counters and allocate-on-taken-miss.
module btb_mem
    import npc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:2] i_lkp_pc,
    output logic              o_hit,
    output logic              o_pred_taken,
    output logic [ADDR_W-1:0] o_target,
    input  logic              i_upd_valid,
    input  logic [ADDR_W-1:2] i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [ADDR_W-1:0] i_upd_target
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              r_valid  [DEPTH];
    ctr_e              r_ctr    [DEPTH];
    logic [TAG_W-1:0]  r_tag    [DEPTH];
    logic [ADDR_W-1:0] r_target [DEPTH];

    logic [IDX_W-1:0] w_lkp_idx;
    logic [TAG_W-1:0] w_lkp_tag;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;

    assign w_lkp_idx = i_lkp_pc[IDX_W+1:2];
    assign w_lkp_tag = i_lkp_pc[ADDR_W-1:IDX_W+2];
    assign w_upd_idx = i_upd_pc[IDX_W+1:2];
    assign w_upd_tag = i_upd_pc[ADDR_W-1:IDX_W+2];

    // Lookup reads the registered array, so a same-cycle update is seen next cycle.
    assign o_hit        = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
    assign o_pred_taken = o_hit && r_ctr[w_lkp_idx][1];
    assign o_target     = r_target[w_lkp_idx];
    assign w_upd_hit    = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= SNT;
            end
        end else if (i_upd_valid) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= ctr_update(r_ctr[w_upd_idx], i_upd_taken);
            end else if (i_upd_taken) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_ctr[w_upd_idx]   <= WT;
            end
        end
    end

    // NOTE: tag/target are qualified by r_valid, so they carry no reset and map to plain RAM.
    always_ff @(posedge clk) begin
        if (i_upd_valid && i_upd_taken) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= i_upd_target;
        end
    end

endmodule

// File: rtl/npc_bpu.sv
// Fetch-stage next-PC unit: PC_F register, BTB prediction, mispredict redirect.
// Optional macro BPU_PERF_CNT_EN adds branch / mispredict performance counters.
module npc_bpu
    import npc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                BTB_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    output logic [ADDR_W-1:0] PC_F,
    output logic              pred_taken_F,
    output logic [ADDR_W-1:0] pred_target_F,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              flush_F
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BTB_DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_upd_plus4;
    logic [ADDR_W-1:0] w_btb_target;
    logic              w_btb_hit;
    logic              w_btb_taken;
    logic              w_mispredict;

    btb_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (BTB_DEPTH),
        .IDX_W  (IDX_W)
    ) u_btb (
        .clk          (clk),
        .reset        (reset),
        .i_lkp_pc     (r_pc[ADDR_W-1:2]),
        .o_hit        (w_btb_hit),
        .o_pred_taken (w_btb_taken),
        .o_target     (w_btb_target),
        .i_upd_valid  (upd_valid),
        .i_upd_pc     (upd_pc[ADDR_W-1:2]),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target)
    );

    assign w_pc_plus4  = r_pc + ADDR_W'(4);
    assign w_upd_plus4 = upd_pc + ADDR_W'(4);

    assign PC_F          = r_pc;
    assign pred_taken_F  = w_btb_taken;
    assign pred_target_F = w_btb_hit ? w_btb_target : w_pc_plus4;

    assign w_mispredict = upd_valid &&
                          ((upd_pred_taken != upd_taken) ||
                           (upd_taken && (upd_pred_target != upd_target)));
    assign flush_F      = w_mispredict && !reset;

    // Redirect from D beats the hazard stall: the stalled F instruction is flushed anyway.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (w_mispredict) begin
            w_pc_next = upd_taken ? upd_target : w_upd_plus4;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (w_btb_taken) begin
            w_pc_next = w_btb_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] r_perf_branches;
    logic [31:0] r_perf_mispredicts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_branches    <= 32'd0;
            r_perf_mispredicts <= 32'd0;
        end else begin
            if (upd_valid) begin
                r_perf_branches <= r_perf_branches + 32'd1;
            end
            if (w_mispredict) begin
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
            end
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_npc_bpu.sv
// Scoreboard bench for npc_bpu: directed steps push expected outputs, a
// negedge monitor pops and compares them.
module tb_npc_bpu;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] PC_F;
    logic        pred_taken_F;
    logic [31:0] pred_target_F;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush_F;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    npc_bpu dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .PC_F            (PC_F),
        .pred_taken_F    (pred_taken_F),
        .pred_target_F   (pred_target_F),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .flush_F         (flush_F)
`ifdef BPU_PERF_CNT_EN
        ,
        .perf_branches   (perf_branches),
        .perf_mispredicts(perf_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic        fl;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int exp_br = 0;
    int exp_mp = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check({e.name, ".pc"},  PC_F, e.pc);
            check({e.name, ".pt"},  {31'd0, pred_taken_F}, {31'd0, e.pt});
            check({e.name, ".tgt"}, pred_target_F, e.tgt);
            check({e.name, ".fl"},  {31'd0, flush_F}, {31'd0, e.fl});
        end
    end

    // One cycle: drive inputs just after the edge and queue the outputs expected this cycle.
    task automatic step(input string nm, input logic rs, input logic st,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg, input logic upt, input logic [31:0] uptg,
                        input logic [31:0] e_pc, input logic e_pt,
                        input logic [31:0] e_tgt, input logic e_fl);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rs;
        stall           = st;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utg;
        upd_pred_taken  = upt;
        upd_pred_target = uptg;
        e.name = nm;
        e.pc   = e_pc;
        e.pt   = e_pt;
        e.tgt  = e_tgt;
        e.fl   = e_fl;
        q.push_back(e);
        if (rs) begin
            exp_br = 0;
            exp_mp = 0;
        end else begin
            if (uv) exp_br++;
            if (e_fl) exp_mp++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1; stall = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        //    name          rs  st  uv  upc       ut  utg       upt uptg         pc        pt  tgt       fl
        step("rst_state",  0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3000, 0, 32'h3004, 0);
        step("seq_3004",   0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3004, 0, 32'h3008, 0);
        step("seq_3008",   0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3008, 0, 32'h300C, 0);
        step("seq_300c",   0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h300C, 0, 32'h3010, 0);
        step("seq_3010",   0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3010, 0, 32'h3014, 0);
        step("mid_reset",  1, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3000, 0, 32'h3004, 0);
        step("rel_reset",  0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3000, 0, 32'h3004, 0);
        step("post_3004",  0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3004, 0, 32'h3008, 0);
        step("stall_a",    0, 1, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3008, 0, 32'h300C, 0);
        step("stall_b",    0, 1, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3008, 0, 32'h300C, 0);
        step("stall_c",    0, 1, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3008, 0, 32'h300C, 0);
        step("stall_redir",0, 1, 1, 32'h3000, 1, 32'h3040, 0, 32'h3004, 32'h3008, 0, 32'h300C, 1);
        step("at_3040",    0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3040, 0, 32'h3044, 0);
        step("j_to_3000",  0, 0, 1, 32'h3104, 1, 32'h3000, 0, 32'h0,    32'h3044, 0, 32'h3048, 1);
        step("pred_hit",   0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3000, 1, 32'h3040, 0);
        step("pred_ok",    0, 0, 1, 32'h3000, 1, 32'h3040, 1, 32'h3040, 32'h3040, 0, 32'h3044, 0);
        step("j2_to_3000", 0, 0, 1, 32'h3104, 1, 32'h3000, 0, 32'h0,    32'h3044, 0, 32'h3048, 1);
        step("sat_t1",     0, 1, 1, 32'h3000, 1, 32'h3040, 1, 32'h3040, 32'h3000, 1, 32'h3040, 0);
        step("sat_t2",     0, 1, 1, 32'h3000, 1, 32'h3040, 1, 32'h3040, 32'h3000, 1, 32'h3040, 0);
        step("sat_t3",     0, 1, 1, 32'h3000, 1, 32'h3040, 1, 32'h3040, 32'h3000, 1, 32'h3040, 0);
        step("sat_n1",     0, 1, 1, 32'h3000, 0, 32'h0,    0, 32'h0,    32'h3000, 1, 32'h3040, 0);
        step("sat_n2",     0, 1, 1, 32'h3000, 0, 32'h0,    0, 32'h0,    32'h3000, 1, 32'h3040, 0);
        step("ctr_wnt",    0, 1, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3000, 0, 32'h3040, 0);
        step("dn_n1",      0, 1, 1, 32'h3000, 0, 32'h0,    0, 32'h0,    32'h3000, 0, 32'h3040, 0);
        step("dn_n2",      0, 1, 1, 32'h3000, 0, 32'h0,    0, 32'h0,    32'h3000, 0, 32'h3040, 0);
        step("ctr_snt",    0, 1, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3000, 0, 32'h3040, 0);
        step("up_t1",      0, 1, 1, 32'h3000, 1, 32'h3040, 1, 32'h3040, 32'h3000, 0, 32'h3040, 0);
        step("up_t2",      0, 1, 1, 32'h3000, 1, 32'h3040, 1, 32'h3040, 32'h3000, 0, 32'h3040, 0);
        step("ctr_wt",     0, 1, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3000, 1, 32'h3040, 0);
        step("alias_upd",  0, 1, 1, 32'h3040, 1, 32'h3080, 1, 32'h3080, 32'h3000, 1, 32'h3040, 0);
        step("alias_miss", 0, 1, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3000, 0, 32'h3004, 0);
        step("run_3000",   0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3000, 0, 32'h3004, 0);
        step("run_3004",   0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3004, 0, 32'h3008, 0);
        step("nt_redir",   0, 0, 1, 32'h3104, 0, 32'h0,    1, 32'h3000, 32'h3008, 0, 32'h300C, 1);
        step("tgt_redir",  0, 0, 1, 32'h3104, 1, 32'h3200, 1, 32'h3000, 32'h3108, 0, 32'h310C, 1);
        step("at_3200",    0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3200, 0, 32'h3204, 0);
        step("nt_to_3104", 0, 0, 1, 32'h3100, 0, 32'h0,    1, 32'h0,    32'h3204, 0, 32'h3208, 1);
        step("new_tgt",    0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3104, 1, 32'h3200, 0);
        step("follow_tgt", 0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h3200, 0, 32'h3204, 0);

        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

`ifdef BPU_PERF_CNT_EN
        check("perf_branches",    perf_branches,    32'(exp_br));
        check("perf_mispredicts", perf_mispredicts, 32'(exp_mp));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npc_bpu.md
Name: npc_bpu

Overview:
- Fetch-stage next-PC unit for the 5-stage MIPS pipeline; parametrised successor of the decode-stage NPC logic.
- Owns the PC_F register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so F can predict j/jal/beq/bne targets.
- D stage reports the resolved outcome. On a misprediction the unit redirects PC_F and flushes the F/D register.

Parameters:
- ADDR_W, 32, PC width in bits.
- BTB_DEPTH, 16, number of BTB entries; power of 2, minimum 2. IDX_W = log2(BTB_DEPTH).
- RESET_PC, 32'h0000_3000, PC_F value after reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC_F (hazard unit stall of F/D).
- PC_F  out  ADDR_W  current fetch PC.
- pred_taken_F  out  1  prediction for PC_F; piped down to D with the instruction.
- pred_target_F  out  ADDR_W  predicted target for PC_F; piped down to D.
- upd_valid  in  1  D holds a j/jal/beq/bne this cycle and D is not stalled.
- upd_pc  in  ADDR_W  PC of that instruction (PC4_D-4).
- upd_taken  in  1  resolved direction (always 1 for j/jal).
- upd_target  in  ADDR_W  resolved target.
- upd_pred_taken  in  1  pred_taken_F carried with the instruction.
- upd_pred_target  in  ADDR_W  pred_target_F carried with the instruction.
- flush_F  out  1  clear F/D register this cycle.

Behaviour:
- Indexing: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
- Each entry holds valid, tag, target[ADDR_W-1:0] and ctr[1:0].
- Lookup is combinational on PC_F. hit = valid & tag match.
  - pred_taken_F = hit & ctr[1].
  - pred_target_F = hit ? target : PC_F+4.
- Mispredict (combinational on upd_*): upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target)).
- flush_F = mispredict, asserted in the same cycle.
- Next PC_F, priority high to low:
  1. mispredict → upd_taken ? upd_target : upd_pc+4. Redirect overrides stall.
  2. stall → hold PC_F.
  3. pred_taken_F → pred_target_F.
  4. otherwise → PC_F+4.
- PC arithmetic is modulo 2^ADDR_W; no overflow flag.
- BTB update on the clk edge when upd_valid:
  - Hit at upd_pc: ctr saturating +1 if taken, saturating -1 if not taken; target <= upd_target if taken.
  - Miss and taken: allocate/overwrite the entry with valid=1, the new tag, target=upd_target, ctr=2'b10 (weakly taken).
  - Miss and not taken: no change.
  - Counter saturates at 2'b11 and 2'b00; no wrap.
- Same-cycle lookup and update on the same index: lookup sees the old contents; the new contents are visible from the next cycle.
- Reset (async, any cycle, including mid-redirect): PC_F=RESET_PC, all valid=0, ctr=2'b00, pred_taken_F=0, flush_F=0.
  - After reset, pred_target_F = RESET_PC+4 (its combinational value).
  - Target and tag fields need no reset.
- Latency: one cycle from upd_valid to redirected PC_F and to updated BTB contents.

Optional Feature:
- Macro BPU_PERF_CNT_EN.
- When defined, adds two 32-bit output ports:
  - perf_branches: count of upd_valid cycles.
  - perf_mispredicts: count of mispredict cycles.
- Both counters wrap at 2^32 and reset to 0 on reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package npc_pkg: localparams OP_J=6'b000010, OP_JAL=6'b000011, OP_BEQ=6'b000100, OP_BNE=6'b000101; the 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11); RESET_PC default.
- One sub-module, btb_mem: entry array, combinational lookup port, synchronous update port, counter saturation logic.
- The top level holds PC_F, the mispredict compare and the next-PC mux.

Test Plan:
- Reset mid-run (assert reset while PC_F=0x3010) → PC_F=0x3000, pred_taken_F=0, flush_F=0; next edges with no stall give 0x3004, 0x3008.
- stall=1 for 3 cycles → PC_F holds its value; stall=1 with a simultaneous mispredict (upd_pc=0x3000, taken, target=0x3040, pred_taken=0) → flush_F=1 and PC_F=0x3040 on the next edge.
- First-time taken beq at 0x3000 → 0x3040 (upd_pred_taken=0) → flush_F=1 and redirect to 0x3040. When fetch returns to 0x3000: pred_taken_F=1, pred_target_F=0x3040, PC_F's next value = 0x3040.
- Counter saturation: 3 taken then 2 not-taken updates at 0x3000 → pred_taken_F at PC_F=0x3000 is 1, 1, 0 across the last three steps (counter states 11→10→01).
- Aliasing with BTB_DEPTH=16: taken branch at 0x3000 then taken branch at 0x3040 (same index, different tag) → entry overwritten; PC_F=0x3000 then gives pred_taken_F=0.
- BPU_PERF_CNT_EN defined: 5 upd_valid cycles, 2 of them mispredicted → perf_branches=5, perf_mispredicts=2.
